oc8051_indi_ptr_bank: RTL and testbench
=======================================

OC8051_INDI_PTR_BANK -- requirements
Module: oc8051_indi_ptr_bank

Interface
REQ-001 SHALL have parameter DW, default 8, meaning pointer/data width in bits.
REQ-002 SHALL have parameter NBANK, default 4, meaning number of register banks (power of two, 1..8).
REQ-003 SHALL have parameter NPTR, default 2, meaning pointer registers per bank (power of two, 1..BANK_STRIDE).
REQ-004 SHALL have parameter BANK_STRIDE, default 8, meaning byte-address spacing between banks (NBANK*BANK_STRIDE <= 256).
REQ-005 SHALL have ports: clk  in  1  clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 wr  in  1  byte write strobe.
REQ-008 wr_bit  in  1  bit-addressable write indication, registered internally.
REQ-009 wr_addr  in  8  write byte address.
REQ-010 data_in  in  DW  write data.
REQ-011 bank  in  log2(NBANK)  active bank select.
REQ-012 sel  in  log2(NPTR)  active pointer select.
REQ-013 ptr_upd  in  1  post-modify the selected pointer (macro-gated).
REQ-014 ptr_dec  in  1  post-modify direction: 0 increment, 1 decrement.
REQ-015 ri_out  out  DW  selected pointer value.
REQ-016 wr_hit  out  1  current write targets a pointer register.

Function
REQ-017 Register (b,p) SHALL map to byte address b*BANK_STRIDE+p; all other addresses SHALL leave storage unchanged and drive wr_hit=0.
REQ-018 wr_bit_r SHALL be wr_bit delayed one clk; wr_hit = wr & !wr_bit_r & address match.
REQ-019 On wr_hit, the addressed register SHALL load data_in at the next rising clk edge.
REQ-020 ri_out SHALL be combinational: data_in when wr_hit targets (bank,sel), else storage[bank][sel] (zero-latency write bypass).
REQ-021 On ptr_upd, storage[bank][sel] SHALL become ri_out+1 (ptr_dec=0) or ri_out-1 (ptr_dec=1) at the next edge, modulo 2^DW (0xFF+1 -> 0x00, 0x00-1 -> 0xFF for DW=8).
REQ-022 Post-modify on the same register as wr_hit SHALL apply to the bypassed data_in (write then modify, one edge).
REQ-023 Post-modify and wr_hit on different registers in the same cycle SHALL both take effect.
REQ-024 Bank/sel changes SHALL take effect on ri_out combinationally with no state change.

Reset
REQ-025 rst high SHALL clear every pointer register and wr_bit_r to 0 immediately; ri_out SHALL read 0 unless bypassing.
REQ-026 rst asserted mid-cycle SHALL discard any pending write or post-modify.

Configuration
REQ-027 With OC8051_INDI_AUTOINC_EN defined, ptr_upd/ptr_dec SHALL behave per REQ-021..023.
REQ-028 Without OC8051_INDI_AUTOINC_EN, ptr_upd/ptr_dec SHALL be ignored and no adder/subtractor logic SHALL be built; ports remain.

Structure
REQ-029 Parameter defaults and the address-to-(bank,ptr) mapping function SHALL live in package oc8051_indi_pkg.
REQ-030 Address decode SHALL be sub-module oc8051_indi_addr_dec (wr_addr -> hit, bank index, ptr index).
REQ-031 Storage SHALL be NBANK*NPTR DW-bit flops; no RAM macro.

Verification
REQ-032 Reset: rst=1 -> all banks read 0x00 across every bank/sel sweep.
REQ-033 Write bank2 p1: wr=1, wr_addr=0x11, data_in=0xA5, bank=2, sel=1 -> ri_out=0xA5 same cycle, held after wr drops, wr_hit=1.
REQ-034 Bit-write suppression: wr_bit=1 one cycle, then wr=1 wr_addr=0x00 data_in=0x3C -> no write, wr_hit=0, R0 bank0 stays 0x00.
REQ-035 Wrap: R1 bank0=0xFF, ptr_upd=1 ptr_dec=0 -> 0x00; then ptr_dec=1 -> 0xFF.
REQ-036 Collision: wr_addr=0x08 data_in=0x10 with ptr_upd=1 ptr_dec=0 on bank1 sel0 -> register 0x11; unmapped wr_addr=0x05 -> no change, wr_hit=0.
REQ-037 Macro off: repeat REQ-035 stimulus -> register unchanged.

Source files
------------

// File: rtl/oc8051_indi_pkg.sv
// ============================================================================
// oc8051_indi_pkg : parameter defaults and byte-address -> (bank, pointer) map
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package oc8051_indi_pkg;

  localparam int unsigned DW_DEFAULT          = 8;
  localparam int unsigned NBANK_DEFAULT       = 4;
  localparam int unsigned NPTR_DEFAULT        = 2;
  localparam int unsigned BANK_STRIDE_DEFAULT = 8;

  // Fields are sized for the largest legal configuration (8 banks, 256-byte map)
  typedef struct packed {
    logic       hit;
    logic [2:0] bank;
    logic [7:0] ptr;
  } ptr_loc_t;

  function automatic ptr_loc_t map_addr(input logic [7:0]  addr,
                                        input int unsigned stride,
                                        input int unsigned nbank,
                                        input int unsigned nptr);
    ptr_loc_t    loc;
    int unsigned b;
    int unsigned p;
    b        = 32'(addr) / stride;
    p        = 32'(addr) % stride;
    loc.hit  = (b < nbank) && (p < nptr);
    loc.bank = 3'(b);
    loc.ptr  = 8'(p);
    return loc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/oc8051_indi_addr_dec.sv
// ============================================================================
// oc8051_indi_addr_dec : decodes a write byte address into hit/bank/pointer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module oc8051_indi_addr_dec
  import oc8051_indi_pkg::*;
#(
  parameter  int unsigned NBANK       = NBANK_DEFAULT,
  parameter  int unsigned NPTR        = NPTR_DEFAULT,
  parameter  int unsigned BANK_STRIDE = BANK_STRIDE_DEFAULT,
  localparam int unsigned BW          = (NBANK > 1) ? $clog2(NBANK) : 1,
  localparam int unsigned PW          = (NPTR > 1) ? $clog2(NPTR) : 1
) (
  input  logic [7:0]    wr_addr,
  output logic          hit,
  output logic [BW-1:0] bank_idx,
  output logic [PW-1:0] ptr_idx
);

  ptr_loc_t w_loc;

  always_comb begin
    w_loc = map_addr(wr_addr, BANK_STRIDE, NBANK, NPTR);
  end

  assign hit      = w_loc.hit;
  assign bank_idx = BW'(w_loc.bank);
  assign ptr_idx  = PW'(w_loc.ptr);

endmodule

`default_nettype wire

// File: rtl/oc8051_indi_ptr_bank.sv
// ============================================================================
// oc8051_indi_ptr_bank : banked indirect-pointer registers (R0/R1 style) with
// write bypass; post-increment/decrement built only with OC8051_INDI_AUTOINC_EN.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module oc8051_indi_ptr_bank
  import oc8051_indi_pkg::*;
#(
  parameter  int unsigned DW          = DW_DEFAULT,
  parameter  int unsigned NBANK       = NBANK_DEFAULT,
  parameter  int unsigned NPTR        = NPTR_DEFAULT,
  parameter  int unsigned BANK_STRIDE = BANK_STRIDE_DEFAULT,
  localparam int unsigned BW          = (NBANK > 1) ? $clog2(NBANK) : 1,
  localparam int unsigned PW          = (NPTR > 1) ? $clog2(NPTR) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          wr_bit,
  input  logic [7:0]    wr_addr,
  input  logic [DW-1:0] data_in,
  input  logic [BW-1:0] bank,
  input  logic [PW-1:0] sel,
  input  logic          ptr_upd,
  input  logic          ptr_dec,
  output logic [DW-1:0] ri_out,
  output logic          wr_hit
);

  logic          r_wr_bit;
  logic [DW-1:0] r_ptr [NBANK][NPTR];
  logic          w_dec_hit;
  logic [BW-1:0] w_dec_bank;
  logic [PW-1:0] w_dec_ptr;
  logic          w_sel_hit;

  oc8051_indi_addr_dec #(
    .NBANK      (NBANK),
    .NPTR       (NPTR),
    .BANK_STRIDE(BANK_STRIDE)
  ) u_addr_dec (
    .wr_addr (wr_addr),
    .hit     (w_dec_hit),
    .bank_idx(w_dec_bank),
    .ptr_idx (w_dec_ptr)
  );

  // A byte write right after a bit-addressable write is the read-modify-write
  // tail of that bit op and must not land in the pointer file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wr_bit <= 1'b0;
    else     r_wr_bit <= wr_bit;
  end

  assign wr_hit    = wr && !r_wr_bit && w_dec_hit;
  assign w_sel_hit = wr_hit && (w_dec_bank == bank) && (w_dec_ptr == sel);
  assign ri_out    = w_sel_hit ? data_in : r_ptr[bank][sel];

`ifdef OC8051_INDI_AUTOINC_EN
  logic [DW-1:0] w_upd_val;
  assign w_upd_val = ptr_dec ? (ri_out - DW'(1)) : (ri_out + DW'(1));
`else
  logic w_unused_upd;
  assign w_unused_upd = ptr_upd ^ ptr_dec;
`endif

  // Post-modify is applied after the write so a same-register collision
  // modifies the freshly written value (via the ri_out bypass).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < int'(NBANK); b++)
        for (int p = 0; p < int'(NPTR); p++)
          r_ptr[b][p] <= '0;
    end else begin
      for (int b = 0; b < int'(NBANK); b++) begin
        for (int p = 0; p < int'(NPTR); p++) begin
          if (wr_hit && (w_dec_bank == BW'(b)) && (w_dec_ptr == PW'(p)))
            r_ptr[b][p] <= data_in;
`ifdef OC8051_INDI_AUTOINC_EN
          if (ptr_upd && (bank == BW'(b)) && (sel == PW'(p)))
            r_ptr[b][p] <= w_upd_val;
`endif
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_oc8051_indi_ptr_bank.sv
// ============================================================================
// tb_oc8051_indi_ptr_bank : directed + random checks against an array model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_oc8051_indi_ptr_bank;

`ifdef OC8051_INDI_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic       wr_bit;
  logic [7:0] wr_addr;
  logic [7:0] data_in;
  logic [1:0] bank;
  logic [0:0] sel;
  logic       ptr_upd;
  logic       ptr_dec;
  logic [7:0] ri_out;
  logic       wr_hit;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mem [4][2];
  bit         m_wbr;

  always #10 clk = ~clk;

  oc8051_indi_ptr_bank dut (
    .clk    (clk),
    .rst    (rst),
    .wr     (wr),
    .wr_bit (wr_bit),
    .wr_addr(wr_addr),
    .data_in(data_in),
    .bank   (bank),
    .sel    (sel),
    .ptr_upd(ptr_upd),
    .ptr_dec(ptr_dec),
    .ri_out (ri_out),
    .wr_hit (wr_hit)
  );

  function automatic bit mapped(input logic [7:0] a);
    return (int'(a) / 8 < 4) && (int'(a) % 8 < 2);
  endfunction

  task automatic model_clear();
    for (int b = 0; b < 4; b++)
      for (int s = 0; s < 2; s++)
        mem[b][s] = 8'h00;
    m_wbr = 1'b0;
  endtask

  // Read every register (no write, no post-modify) and compare with the model
  task automatic sweep(input string tag);
    @(negedge clk);
    wr = 1'b0; wr_bit = 1'b0; ptr_upd = 1'b0; ptr_dec = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < 2; s++) begin
        bank = 2'(b); sel = 1'(s);
        #1;
        n_chk++;
        assert (ri_out === mem[b][s]) else begin
          n_fail++;
          $error("FAIL %s b%0d s%0d: ri_out=%h expected=%h", tag, b, s, ri_out, mem[b][s]);
        end
      end
    end
    @(posedge clk);
    if (!rst) m_wbr = 1'b0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model
  task automatic step(input string tag, input bit w, input bit wb, input logic [7:0] a,
                      input logic [7:0] d, input logic [1:0] b, input logic [0:0] s,
                      input bit u, input bit dec);
    bit         e_hit;
    logic [7:0] e_ri;
    @(negedge clk);
    wr = w; wr_bit = wb; wr_addr = a; data_in = d;
    bank = b; sel = s; ptr_upd = u; ptr_dec = dec;
    #2;
    e_hit = w && !m_wbr && mapped(a);
    e_ri  = (e_hit && (int'(a) / 8 == int'(b)) && (int'(a) % 8 == int'(s))) ? d : mem[b][s];
    n_chk++;
    assert (wr_hit === e_hit) else begin
      n_fail++;
      $error("FAIL %s wr_hit: got=%b expected=%b", tag, wr_hit, e_hit);
    end
    n_chk++;
    assert (ri_out === e_ri) else begin
      n_fail++;
      $error("FAIL %s ri_out: got=%h expected=%h", tag, ri_out, e_ri);
    end
    @(posedge clk);
    if (e_hit) mem[int'(a) / 8][int'(a) % 8] = d;
    if (AUTO && u) mem[b][s] = dec ? e_ri - 8'd1 : e_ri + 8'd1;
    m_wbr = wb;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; wr_bit = 1'b0; wr_addr = 8'h00; data_in = 8'h00;
    bank = 2'd0; sel = 1'b0; ptr_upd = 1'b0; ptr_dec = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    sweep("reset");
    @(negedge clk);
    rst = 1'b0;

    // Write bank2 R1 with same-cycle bypass, then held
    step("wr_b2p1",   1, 0, 8'h11, 8'hA5, 2'd2, 1'b1, 0, 0);
    step("hold_b2p1", 0, 0, 8'h11, 8'h00, 2'd2, 1'b1, 0, 0);

    // Byte write right after a bit write is suppressed
    step("bitwr",     0, 1, 8'h00, 8'h00, 2'd0, 1'b0, 0, 0);
    step("bit_supp",  1, 0, 8'h00, 8'h3C, 2'd0, 1'b0, 0, 0);
    step("bit_after", 0, 0, 8'h00, 8'h00, 2'd0, 1'b0, 0, 0);

    // Wrap-around post-modify on bank0 R1
    step("ld_ff",     1, 0, 8'h01, 8'hFF, 2'd0, 1'b1, 0, 0);
    step("inc_wrap",  0, 0, 8'h00, 8'h00, 2'd0, 1'b1, 1, 0);
    step("dec_wrap",  0, 0, 8'h00, 8'h00, 2'd0, 1'b1, 1, 1);
    step("after_dec", 0, 0, 8'h00, 8'h00, 2'd0, 1'b1, 0, 0);

    // Same-register write + post-modify, then unmapped write
    step("coll_wr",   1, 0, 8'h08, 8'h10, 2'd1, 1'b0, 1, 0);
    step("coll_rd",   0, 0, 8'h00, 8'h00, 2'd1, 1'b0, 0, 0);
    step("unmapped",  1, 0, 8'h05, 8'h77, 2'd1, 1'b0, 0, 0);
    step("hi_addr",   1, 0, 8'h20, 8'h66, 2'd0, 1'b0, 0, 0);

    // Write and post-modify on different registers in one cycle
    step("split",     1, 0, 8'h18, 8'h42, 2'd0, 1'b0, 1, 1);
    sweep("directed");

    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      if ($urandom_range(0, 1) == 1) a = 8'(($urandom_range(0, 3) * 8) + $urandom_range(0, 1));
      else                           a = 8'($urandom_range(0, 255));
      step("rand", bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a,
           8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end
    sweep("random");

    // Asynchronous reset in the middle of a cycle with a write pending
    @(negedge clk);
    wr = 1'b1; wr_bit = 1'b0; wr_addr = 8'h00; data_in = 8'h55;
    bank = 2'd0; sel = 1'b0; ptr_upd = 1'b1; ptr_dec = 1'b0;
    #3;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    sweep("midrst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst",  1, 0, 8'h19, 8'h5A, 2'd3, 1'b1, 0, 0);
    sweep("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
